// File: rtl/arbiter_pkg.sv
// Shared types for the SRAM port arbiter: FSM state encoding and a width helper.
package arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request bit at or above ptr, wrapping.
module rr_picker #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int j;

  // Scan from the lowest priority down so the highest-priority hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between N_REQ requesters,
// with bounded bursts and a one-cycle read-return strobe per requester.
module sram_port_arbiter
  import arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 3,
  parameter int MAX_BURST  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_din,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        sram_cs,
  output logic                        sram_we,
  output logic [ADDR_WIDTH-1:0]       sram_addr,
  output logic [DATA_WIDTH-1:0]       sram_din,
  input  logic [DATA_WIDTH-1:0]       sram_dout,
  output logic                        busy,
  output arb_state_t                  dbg_state
);

  localparam int IDX_W  = width_of(N_REQ);
  localparam int BCNT_W = width_of(MAX_BURST);

  // Handshake: req[i] is a level. Once gnt[i] is high, every cycle with
  // req[i]=1 is one SRAM access (no stall); dropping req[i] ends the grant.
  // rvalid[i] pulses for exactly one cycle, one cycle after each read access.

  arb_state_t         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [BCNT_W-1:0]  bcnt;
  logic [N_REQ-1:0]   rd_pend;

  logic [N_REQ-1:0]   owner_oh;
  logic [IDX_W-1:0]   next_ptr;
  logic               access;
  logic               others_waiting;
  logic               last_beat;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_oh       = N_REQ'(1) << owner;
  assign access         = (state == ARB_GRANT) && req[owner];
  assign others_waiting = |(req & ~owner_oh);
  assign last_beat      = (bcnt == BCNT_W'(MAX_BURST - 1));
  assign next_ptr       = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

  // SRAM port follows the owner's slices only during an access, else parks at zero.
  always_comb begin
    sram_cs   = access;
    sram_we   = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    if (access) begin
      sram_we   = req_we[owner];
      sram_addr = req_addr[owner*ADDR_WIDTH +: ADDR_WIDTH];
      sram_din  = req_din[owner*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // rd_pend is already the one-cycle-late strobe; SRAM data lines up with it.
  assign rvalid    = rd_pend;
  assign rdata     = (|rd_pend) ? sram_dout : '0;
  assign busy      = (state != ARB_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB_IDLE;
      ptr     <= '0;
      owner   <= '0;
      bcnt    <= '0;
      gnt     <= '0;
      rd_pend <= '0;
    end else begin
      rd_pend <= (access && !req_we[owner]) ? owner_oh : '0;
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            owner <= pick_idx;
            gnt   <= N_REQ'(1) << pick_idx;
            bcnt  <= '0;
            state <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (!req[owner]) begin
            gnt   <= '0;
            ptr   <= next_ptr;
            state <= ARB_RELEASE;
          end else if (last_beat) begin
            // Burst boundary: yield only if someone else is actually waiting.
            bcnt <= '0;
            if (others_waiting) begin
              gnt   <= '0;
              ptr   <= next_ptr;
              state <= ARB_RELEASE;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        ARB_RELEASE: state <= ARB_IDLE;
        default:     state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Round-robin arbiter that shares one single-port `sram` instance between up to `N_REQ` requesters, such as the grouper, the encoder sequencer and a host loader, replacing ad-hoc `done`-based address muxing. It owns the SRAM port signals (`cs`, `we`, `addr`, `din`). It grants one requester at a time with a bounded burst length. It returns read data with a per-requester valid strobe aligned to the SRAM's 1-cycle read latency.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: SRAM address width.
- `DATA_WIDTH`, default 8: SRAM data width.
- `N_REQ`, default 3: number of requesters, 2..8.
- `MAX_BURST`, default 8: maximum consecutive accesses per grant when others are waiting, ≥1.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  per-requester access request, level.
- `req_we`  in  N_REQ  per-requester write enable, meaningful when req=1.
- `req_addr`  in  N_REQ*ADDR_WIDTH  flattened addresses; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_din`  in  N_REQ*DATA_WIDTH  flattened write data, sliced the same way.
- `gnt`  out  N_REQ  registered one-hot grant.
- `rvalid`  out  N_REQ  one-hot read-data strobe.
- `rdata`  out  DATA_WIDTH  read data broadcast to all requesters; qualified by `rvalid`.
- `sram_cs`, `sram_we`  out  1  SRAM port controls.
- `sram_addr`  out  ADDR_WIDTH  SRAM address.
- `sram_din`  out  DATA_WIDTH  SRAM write data.
- `sram_dout`  in  DATA_WIDTH  SRAM read data, valid 1 cycle after a read access.
- `busy`  out  1  high whenever the state is not ARB_IDLE.

## Operation
- FSM states: ARB_IDLE, ARB_GRANT, ARB_RELEASE.
- Registers:
  - `ptr`: round-robin pointer, reset 0.
  - `owner`: index of the granted requester.
  - `bcnt`: burst counter, reset 0.
  - `rd_pend`: one-hot pending-read register.
- ARB_IDLE: if any `req` bit is set, pick the first set bit searching from `ptr` upward with wrap. Load `owner` and set `gnt[owner]`. Clear `bcnt`. Go to ARB_GRANT. Otherwise stay in ARB_IDLE.
- Access cycle: any cycle in ARB_GRANT where `req[owner]`=1.
  - `sram_cs`=1.
  - `sram_we`, `sram_addr` and `sram_din` are taken from the owner's slices, combinationally.
  - `bcnt` increments.
- ARB_GRANT with `req[owner]`=0: no access (`sram_cs`=0). Clear `gnt`, set `ptr`=owner+1 mod N_REQ, go to ARB_RELEASE.
- Burst limit: on the access cycle where `bcnt` reaches MAX_BURST−1, with any other `req` bit set:
  - the access completes;
  - `gnt` is cleared next cycle;
  - `ptr`=owner+1;
  - state goes to ARB_RELEASE.
  If no other requester is pending, `bcnt` resets to 0 and the grant continues.
- ARB_RELEASE: one dead cycle with no access. Go to ARB_IDLE. This prevents back-to-back ownership changes within one SRAM cycle.
- Read return: a read access (`sram_we`=0) sets `rd_pend[owner]`. The next cycle drives `rvalid` = `rd_pend` and `rdata` = `sram_dout`.
- Writes never produce `rvalid`.
- Outside an access cycle, `sram_addr`, `sram_din` and `sram_we` are 0.

## Timing
- Reset values: `gnt`=0, `rvalid`=0, `busy`=0, `sram_cs`=0, `sram_we`=0, `sram_addr`=0, `sram_din`=0, `rdata`=0, state ARB_IDLE.
- Grant latency: `req` is sampled high at edge t in ARB_IDLE, `gnt` goes high after t, and the first access happens in the cycle following t.
- Read latency: an access in cycle k gives `rvalid`/`rdata` in cycle k+1. This holds even if the grant was released at the end of cycle k.
- Handover cost: 2 cycles (ARB_RELEASE then ARB_IDLE) between the last access of one owner and `gnt` of the next.
- Simultaneous requests: resolved strictly by the rotating priority from `ptr`. No requester waits more than (N_REQ−1) bursts plus overhead.
- A requester that drops and re-raises `req` while granted loses ownership and re-arbitrates.
- Asynchronous reset mid-burst clears `gnt`, `rd_pend` and `rvalid` immediately. An in-flight read is discarded.

## Structure
- Package `arbiter_pkg` holds the `arb_state_t` enum (ARB_IDLE, ARB_GRANT, ARB_RELEASE).
- Sub-module `rr_picker`: combinational first-set search from `ptr` with wrap. It outputs `found` and the index.
- Top level holds the FSM, counters, SRAM muxing and the read-return pipeline.

## Test plan
- Single requester: req0 reads addr 3 (SRAM holds 0x5A) → gnt0 one cycle after req, `rvalid[0]`=1 and `rdata`=0x5A one cycle after the access.
- Write then read: req1 writes 0xC3 to addr 7, drops req, re-requests a read of addr 7 → `rdata`=0xC3 with `rvalid[1]`; no `rvalid` on the write.
- Three simultaneous requests from reset (ptr=0) → grant order 0, 1, 2, 0, …, with a 2-cycle gap between owners.
- Burst limit with MAX_BURST=8: req0 held continuously and req2 waiting → exactly 8 accesses by 0, then gnt2. With req0 alone, grant persists beyond 16 accesses.
- Owner drops req mid-burst after 3 accesses → `sram_cs`=0 that cycle, ARB_RELEASE, and ptr advances to 1.
- `rst` asserted the cycle after a read access → `rvalid`=0, `gnt`=0, `busy`=0 immediately; after release, arbitration restarts from ptr=0.
